// File: rtl/retire_stage.sv
// retire_stage: in-order commit stage of the R10K pipeline.
// Retires up to N_WAY completed ROB-head entries per cycle, updates the
// architectural map, hands each retiring T_old to the free list, raises a
// one-cycle flush after a mispredicted branch and latches halted after a halt.
// Optional feature macro: RETIRE_STATS_EN adds a 64-bit retired_insts counter.

`ifndef N
`define N 3
`endif
`ifndef PHYS_REG_SZ_R10K
`define PHYS_REG_SZ_R10K 64
`endif

module retire_stage #(
  parameter int N_WAY     = `N,
  parameter int ARCH_REGS = 32,
  parameter int PHYS_REGS = `PHYS_REG_SZ_R10K,
  parameter int PREG_BITS = $clog2(PHYS_REGS),
  parameter int CNT_BITS  = $clog2(N_WAY + 1)
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [N_WAY-1:0]                      head_valid,
  input  logic [N_WAY-1:0]                      head_complete,
  input  logic [N_WAY-1:0]                      head_has_dest,
  input  logic [N_WAY-1:0][4:0]                 head_arch_dest,
  input  logic [N_WAY-1:0][PREG_BITS-1:0]       head_T,
  input  logic [N_WAY-1:0][PREG_BITS-1:0]       head_T_old,
  input  logic [N_WAY-1:0]                      head_mispredict,
  input  logic [N_WAY-1:0]                      head_halt,
  output logic [CNT_BITS-1:0]                   rob_pop,
  output logic [N_WAY-1:0][PREG_BITS-1:0]       free_regs,
  output logic [CNT_BITS-1:0]                   free_count,
  output logic                                  flush,
  output logic [ARCH_REGS-1:0][PREG_BITS-1:0]   arch_map,
  output logic                                  halted
`ifdef RETIRE_STATS_EN
  ,
  output logic [63:0]                           retired_insts
`endif
);

  logic [N_WAY-1:0]                retire_mask;
  logic [CNT_BITS-1:0]             retire_cnt;
  logic                            run;
  logic                            mispredict_retire;
  logic                            halt_retire;
  logic [N_WAY-1:0][PREG_BITS-1:0] free_next;
  logic [CNT_BITS-1:0]             free_cnt_next;

  // Find the leading run of completed slots, stopping after a branch
  // mispredict or halt; nothing retires under reset, flush or halt.
  always_comb begin
    retire_mask       = '0;
    retire_cnt        = '0;
    run               = 1'b1;
    mispredict_retire = 1'b0;
    halt_retire       = 1'b0;
    if (!(reset || flush || halted)) begin
      for (int i = 0; i < N_WAY; i++) begin
        if (run && head_valid[i] && head_complete[i]) begin
          retire_mask[i] = 1'b1;
          retire_cnt     = retire_cnt + CNT_BITS'(1);
          if (head_mispredict[i]) mispredict_retire = 1'b1;
          if (head_halt[i])       halt_retire       = 1'b1;
          if (head_mispredict[i] || head_halt[i]) run = 1'b0;
        end else begin
          run = 1'b0;
        end
      end
    end
  end

  assign rob_pop = retire_cnt;

  // Pack the T_olds of retiring destination-writing slots, oldest first.
  always_comb begin
    free_next     = '0;
    free_cnt_next = '0;
    for (int i = 0; i < N_WAY; i++) begin
      if (retire_mask[i] && head_has_dest[i]) begin
        free_next[free_cnt_next] = head_T_old[i];
        free_cnt_next            = free_cnt_next + CNT_BITS'(1);
      end
    end
  end

  // Register the free-list handoff, flush pulse and sticky halt.
  always_ff @(posedge clock) begin
    if (reset) begin
      free_regs  <= '0;
      free_count <= '0;
      flush      <= 1'b0;
      halted     <= 1'b0;
    end else begin
      free_regs  <= free_next;
      free_count <= free_cnt_next;
      flush      <= mispredict_retire;
      halted     <= halted | halt_retire;
    end
  end

  // Commit new mappings; ascending slot order lets the younger slot win
  // on a duplicate destination, and x0 is never remapped.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < ARCH_REGS; r++) begin
        arch_map[r] <= PREG_BITS'(r);
      end
    end else begin
      for (int i = 0; i < N_WAY; i++) begin
        if (retire_mask[i] && head_has_dest[i] && (head_arch_dest[i] != 5'd0)) begin
          arch_map[head_arch_dest[i]] <= head_T[i];
        end
      end
    end
  end

`ifdef RETIRE_STATS_EN
  // Running total of retired instructions.
  always_ff @(posedge clock) begin
    if (reset) begin
      retired_insts <= '0;
    end else begin
      retired_insts <= retired_insts + 64'(retire_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_retire_stage.sv
// tb_retire_stage: directed bench for retire_stage with N_WAY=3, PHYS_REGS=64.
// Inputs change #1 after the rising edge; outputs are checked there too.

module tb_retire_stage;

  localparam int N_WAY     = 3;
  localparam int ARCH_REGS = 32;
  localparam int PHYS_REGS = 64;
  localparam int PREG_BITS = 6;
  localparam int CNT_BITS  = 2;

  logic                                clock;
  logic                                reset;
  logic [N_WAY-1:0]                    head_valid;
  logic [N_WAY-1:0]                    head_complete;
  logic [N_WAY-1:0]                    head_has_dest;
  logic [N_WAY-1:0][4:0]               head_arch_dest;
  logic [N_WAY-1:0][PREG_BITS-1:0]     head_T;
  logic [N_WAY-1:0][PREG_BITS-1:0]     head_T_old;
  logic [N_WAY-1:0]                    head_mispredict;
  logic [N_WAY-1:0]                    head_halt;
  logic [CNT_BITS-1:0]                 rob_pop;
  logic [N_WAY-1:0][PREG_BITS-1:0]     free_regs;
  logic [CNT_BITS-1:0]                 free_count;
  logic                                flush;
  logic [ARCH_REGS-1:0][PREG_BITS-1:0] arch_map;
  logic                                halted;
`ifdef RETIRE_STATS_EN
  logic [63:0]                         retired_insts;
`endif

  int compared = 0;
  int mismatched = 0;

  retire_stage #(
    .N_WAY(N_WAY), .ARCH_REGS(ARCH_REGS), .PHYS_REGS(PHYS_REGS)
  ) dut (
    .clock(clock), .reset(reset),
    .head_valid(head_valid), .head_complete(head_complete),
    .head_has_dest(head_has_dest), .head_arch_dest(head_arch_dest),
    .head_T(head_T), .head_T_old(head_T_old),
    .head_mispredict(head_mispredict), .head_halt(head_halt),
    .rob_pop(rob_pop), .free_regs(free_regs), .free_count(free_count),
    .flush(flush), .arch_map(arch_map), .halted(halted)
`ifdef RETIRE_STATS_EN
    , .retired_insts(retired_insts)
`endif
  );

  // Free-running clock, 10 ns period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic clearHead();
    head_valid = '0; head_complete = '0; head_has_dest = '0;
    head_arch_dest = '0; head_T = '0; head_T_old = '0;
    head_mispredict = '0; head_halt = '0;
  endtask

  task automatic applyStimulus(input int slot, input bit v, input bit c, input bit hd,
                               input int dest, input int t, input int told,
                               input bit mp, input bit h);
    head_valid[slot]      = v;
    head_complete[slot]   = c;
    head_has_dest[slot]   = hd;
    head_arch_dest[slot]  = 5'(dest);
    head_T[slot]          = PREG_BITS'(t);
    head_T_old[slot]      = PREG_BITS'(told);
    head_mispredict[slot] = mp;
    head_halt[slot]       = h;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    $display("[TB] starting retire_stage directed test");
    clearHead();
    reset = 1'b1;
    tick();
    tick();

    // Reset: no retirement even with complete entries at the head
    applyStimulus(0, 1, 1, 1, 3, 33, 3, 0, 0);
    #1;
    checkOutput("reset_rob_pop", 64'(rob_pop), 64'd0);
    checkOutput("reset_map5", 64'(arch_map[5]), 64'd5);
    checkOutput("reset_free_count", 64'(free_count), 64'd0);
    checkOutput("reset_flush", 64'(flush), 64'd0);
    checkOutput("reset_halted", 64'(halted), 64'd0);
    clearHead();

    // 1: idle after reset
    reset = 1'b0;
    tick();
    checkOutput("idle_map5", 64'(arch_map[5]), 64'd5);
    checkOutput("idle_free_count", 64'(free_count), 64'd0);
    checkOutput("idle_flush", 64'(flush), 64'd0);
    checkOutput("idle_rob_pop", 64'(rob_pop), 64'd0);

    // 2: three complete slots, last has no destination
    applyStimulus(0, 1, 1, 1, 5, 40, 5, 0, 0);
    applyStimulus(1, 1, 1, 1, 6, 41, 6, 0, 0);
    applyStimulus(2, 1, 1, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("t2_rob_pop", 64'(rob_pop), 64'd3);
    tick();
    clearHead();
    checkOutput("t2_free_count", 64'(free_count), 64'd2);
    checkOutput("t2_free0", 64'(free_regs[0]), 64'd5);
    checkOutput("t2_free1", 64'(free_regs[1]), 64'd6);
    checkOutput("t2_free2", 64'(free_regs[2]), 64'd0);
    checkOutput("t2_map5", 64'(arch_map[5]), 64'd40);
    checkOutput("t2_map6", 64'(arch_map[6]), 64'd41);
    checkOutput("t2_map0", 64'(arch_map[0]), 64'd0);
    tick();
    checkOutput("idle_free_count_zero", 64'(free_count), 64'd0);

    // 3: gap in the middle stops retirement at slot 0
    applyStimulus(0, 1, 1, 1, 8, 44, 8, 0, 0);
    applyStimulus(1, 1, 0, 1, 9, 45, 9, 0, 0);
    applyStimulus(2, 1, 1, 1, 10, 46, 10, 0, 0);
    #1;
    checkOutput("t3_rob_pop", 64'(rob_pop), 64'd1);
    tick();
    clearHead();
    checkOutput("t3_free_count", 64'(free_count), 64'd1);
    checkOutput("t3_free0", 64'(free_regs[0]), 64'd8);
    checkOutput("t3_free1", 64'(free_regs[1]), 64'd0);
    checkOutput("t3_map8", 64'(arch_map[8]), 64'd44);
    checkOutput("t3_map9", 64'(arch_map[9]), 64'd9);
    checkOutput("t3_map10", 64'(arch_map[10]), 64'd10);

    // 4: duplicate destination, younger slot wins
    applyStimulus(0, 1, 1, 1, 7, 42, 7, 0, 0);
    applyStimulus(1, 1, 1, 1, 7, 43, 42, 0, 0);
    #1;
    checkOutput("t4_rob_pop", 64'(rob_pop), 64'd2);
    tick();
    clearHead();
    checkOutput("t4_map7", 64'(arch_map[7]), 64'd43);
    checkOutput("t4_free_count", 64'(free_count), 64'd2);
    checkOutput("t4_free0", 64'(free_regs[0]), 64'd7);
    checkOutput("t4_free1", 64'(free_regs[1]), 64'd42);

    // 5a: mispredict on slot 1 ends the group and flushes next cycle
    applyStimulus(0, 1, 1, 1, 11, 47, 11, 0, 0);
    applyStimulus(1, 1, 1, 1, 12, 48, 12, 1, 0);
    applyStimulus(2, 1, 1, 1, 13, 49, 13, 0, 0);
    #1;
    checkOutput("t5_rob_pop", 64'(rob_pop), 64'd2);
    tick();
    checkOutput("t5_flush", 64'(flush), 64'd1);
    checkOutput("t5_map12", 64'(arch_map[12]), 64'd48);
    checkOutput("t5_map13", 64'(arch_map[13]), 64'd13);
    checkOutput("t5_free_count", 64'(free_count), 64'd2);
    checkOutput("t5_flush_rob_pop", 64'(rob_pop), 64'd0);
    tick();
    clearHead();
    checkOutput("t5_flush_clear", 64'(flush), 64'd0);
    checkOutput("t5_post_free_count", 64'(free_count), 64'd0);

    // 5b: halt on slot 0 retires alone, halted is sticky
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 0, 1);
    applyStimulus(1, 1, 1, 1, 14, 50, 14, 0, 0);
    #1;
    checkOutput("t5_halt_rob_pop", 64'(rob_pop), 64'd1);
    tick();
    checkOutput("t5_halted", 64'(halted), 64'd1);
    checkOutput("t5_halt_map14", 64'(arch_map[14]), 64'd14);
    checkOutput("t5_halt_blocks", 64'(rob_pop), 64'd0);
    tick();
    clearHead();
    checkOutput("t5_halted_sticky", 64'(halted), 64'd1);

    // 5c: reset during a flush cycle restores everything
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(0, 1, 1, 1, 15, 51, 15, 1, 0);
    #1;
    checkOutput("t5c_halted_cleared", 64'(halted), 64'd0);
    checkOutput("t5c_rob_pop", 64'(rob_pop), 64'd1);
    tick();
    checkOutput("t5c_flush", 64'(flush), 64'd1);
    checkOutput("t5c_map15", 64'(arch_map[15]), 64'd51);
    reset = 1'b1;
    #1;
    checkOutput("t5c_reset_rob_pop", 64'(rob_pop), 64'd0);
    tick();
    clearHead();
    checkOutput("t5c_flush_reset", 64'(flush), 64'd0);
    checkOutput("t5c_map15_reset", 64'(arch_map[15]), 64'd15);
    checkOutput("t5c_map7_reset", 64'(arch_map[7]), 64'd7);
    checkOutput("t5c_free_count_reset", 64'(free_count), 64'd0);
    checkOutput("t5c_free0_reset", 64'(free_regs[0]), 64'd0);
    checkOutput("t5c_halted_reset", 64'(halted), 64'd0);
`ifdef RETIRE_STATS_EN
    checkOutput("t5c_retired_reset", retired_insts, 64'd0);
`endif
    reset = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
